// File: rtl/vga_pkg.sv
// Shared timing constants and the raster signal bundle type for the video pipeline.
package vga_pkg;

    // 1024x768@60 Hz timing at a 65 MHz pixel clock
    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 11;

    // Everything one pixel carries down the pipeline
    typedef struct packed {
        logic [VCOUNT_W-1:0] vcount;
        logic                vsync;
        logic                vblnk;
        logic [HCOUNT_W-1:0] hcount;
        logic                hsync;
        logic                hblnk;
        logic [11:0]         rgb;
    } vga_sig_t;

endpackage

// File: rtl/vga_if.sv
// Raster bundle passed from stage to stage; out = producer side, in = consumer side.
interface vga_if;
    import vga_pkg::*;

    logic [VCOUNT_W-1:0] vcount;
    logic                vsync;
    logic                vblnk;
    logic [HCOUNT_W-1:0] hcount;
    logic                hsync;
    logic                hblnk;
    logic [11:0]         rgb;

    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with blanking and raw sync flags.
// Flags are registered from the next count so they line up with the count register.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE,
    parameter int FP     = H_FP,
    parameter int SYNC   = H_SYNC,
    parameter int BP     = H_BP,
    parameter int W      = HCOUNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         blnk,
    output logic         sync_raw,
    output logic         wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    // Reject timings whose total does not fit the counter width
    generate
        if (TOTAL > (1 << W) || TOTAL < 2) begin : g_bad_total
            $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, W);
        end
    endgenerate

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;
    logic         blnk_reg;
    logic         sync_reg;

    // wrap marks the edge on which the counter returns to zero
    assign wrap = inc && (count_reg == LAST);

    // Next position: hold, wrap, or step
    always_comb begin
        count_next = count_reg;
        if (inc) begin
            count_next = wrap ? '0 : count_reg + 1'b1;
        end
    end

    // Register the count and the flags derived from the position being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            blnk_reg  <= 1'b0;
            sync_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            blnk_reg  <= (count_next >= ACT_END);
            sync_reg  <= (count_next >= SYNC_START) && (count_next < SYNC_END);
        end
    end

    assign count    = count_reg;
    assign blnk     = blnk_reg;
    assign sync_raw = sync_reg;

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: head of the video pipeline, plus per-frame and
// per-line strobes for game logic.
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE_P       = H_ACTIVE,
    parameter int   H_FP_P           = H_FP,
    parameter int   H_SYNC_P         = H_SYNC,
    parameter int   H_BP_P           = H_BP,
    parameter int   V_ACTIVE_P       = V_ACTIVE,
    parameter int   V_FP_P           = V_FP,
    parameter int   V_SYNC_P         = V_SYNC,
    parameter int   V_BP_P           = V_BP,
    parameter logic SYNC_ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    vga_if.out   vout,
    output logic frame_start,
    output logic line_start
);

    logic [HCOUNT_W-1:0] h_count;
    logic                h_blnk;
    logic                h_sync_raw;
    logic                h_wrap;
    logic [VCOUNT_W-1:0] v_count;
    logic                v_blnk;
    logic                v_sync_raw;
    logic                v_wrap;
    logic                v_inc;
    logic                frame_start_reg;
    logic                line_start_reg;
    vga_sig_t            sig;

    // Vertical axis steps once per horizontal wrap
    assign v_inc = en & h_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE_P),
        .FP     (H_FP_P),
        .SYNC   (H_SYNC_P),
        .BP     (H_BP_P),
        .W      (HCOUNT_W)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (en),
        .count    (h_count),
        .blnk     (h_blnk),
        .sync_raw (h_sync_raw),
        .wrap     (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE_P),
        .FP     (V_FP_P),
        .SYNC   (V_SYNC_P),
        .BP     (V_BP_P),
        .W      (VCOUNT_W)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (v_inc),
        .count    (v_count),
        .blnk     (v_blnk),
        .sync_raw (v_sync_raw),
        .wrap     (v_wrap)
    );

    // Strobes fire in the cycle the line/frame origin is entered; h_wrap already includes en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            line_start_reg  <= h_wrap;
            frame_start_reg <= h_wrap & v_wrap;
        end
    end

    // Assemble the bundle; raw sync of 0 maps to the inactive level for either polarity
    always_comb begin
        sig        = '0;
        sig.vcount = v_count;
        sig.vsync  = ~(v_sync_raw ^ SYNC_ACTIVE_HIGH);
        sig.vblnk  = v_blnk;
        sig.hcount = h_count;
        sig.hsync  = ~(h_sync_raw ^ SYNC_ACTIVE_HIGH);
        sig.hblnk  = h_blnk;
        sig.rgb    = 12'h000;
    end

    assign vout.vcount = sig.vcount;
    assign vout.vsync  = sig.vsync;
    assign vout.vblnk  = sig.vblnk;
    assign vout.hcount = sig.hcount;
    assign vout.hsync  = sig.hsync;
    assign vout.hblnk  = sig.hblnk;
    assign vout.rgb    = sig.rgb;

    assign frame_start = frame_start_reg;
    assign line_start  = line_start_reg;

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates 1024x768@60 Hz VGA raster timing and drives a vga_if.out bundle.
- It is the producer end of the interface that draw_bg and every later draw stage consume.
- Sits first in the video pipeline, clocked by the 65 MHz pixel clock.
- Also emits single-cycle frame_start and line_start strobes, used by game logic (bird and pipe update, scroll) to advance once per frame.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch in clocks
- H_SYNC, 136, horizontal sync width in clocks
- H_BP, 160, horizontal back porch in clocks
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch in lines
- V_SYNC, 6, vertical sync width in lines
- V_BP, 29, vertical back porch in lines
- SYNC_ACTIVE_HIGH, 1'b1, polarity of hsync/vsync on vout

Ports:
- clk, input, 1, pixel clock
- rst_n, input, 1, asynchronous active-low reset
- en, input, 1, count enable; when low, all state freezes
- vout, vga_if.out, bundle, vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]
- frame_start, output, 1, one-clock pulse at hcount=0, vcount=0
- line_start, output, 1, one-clock pulse at hcount=0 of every line

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344 by default).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806 by default).
  - Both must fit in 11 bits; an out-of-range value is an elaboration error.
- Counters: hcount and vcount are registered 11-bit counters, updated only when en=1.
  - hcount: 0 .. H_TOTAL-1, wraps to 0.
  - vcount: increments when hcount wraps; 0 .. V_TOTAL-1, wraps to 0 when hcount and vcount both wrap.
- All vout fields and strobes are registered and computed from the next counter values, so every field refers to the same pixel as hcount/vcount in the same cycle. Latency from counter to outputs is zero cycles.
- hblnk = 1 when hcount >= H_ACTIVE.
- vblnk = 1 when vcount >= V_ACTIVE.
- Raw horizontal sync is 1 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 1048..1183. Raw vertical sync is 1 for vcount in [771, 777). Outputs are hsync/vsync = raw XNOR SYNC_ACTIVE_HIGH.
- vout.rgb is always 12'h000; colour is added by downstream draw stages.
- frame_start = 1 exactly when (hcount,vcount) = (0,0) and en=1 in the cycle that value was entered.
- line_start = 1 exactly when hcount=0 and en=1 in the cycle that value was entered.
- en=0: counters hold, vout fields hold, strobes forced to 0. When en returns to 1, counting resumes from the held position; no strobe repeats for an already-entered position.
- Reset (rst_n=0, asynchronous):
  - hcount=0, vcount=0, hblnk=0, vblnk=0, rgb=0.
  - hsync/vsync at their inactive level (0 when SYNC_ACTIVE_HIGH=1).
  - frame_start=0, line_start=0.
- First cycle after release with en=1: counters advance to (1,0); no frame_start. The first frame_start occurs at the first wrap.
- Reset asserted mid-line or mid-frame clears immediately, without waiting for a clock edge.
- Simultaneous hcount and vcount wrap: both go to 0 in the same cycle; frame_start and line_start are both 1.

Decomposition:
- vga_pkg holds:
  - the default timing constants listed under Parameters (module parameters default to them);
  - HCOUNT_W = 11 and VCOUNT_W = 11;
  - a struct typedef vga_sig_t containing {vcount, vsync, vblnk, hcount, hsync, hblnk, rgb}.
- One sub-module, vga_axis_counter, parameterised by ACTIVE, FP, SYNC, BP. Ports: clk, rst_n, inc, count, blnk, sync_raw, wrap.
  - Instantiated twice: horizontal with inc=en; vertical with inc=en & h_wrap.
  - The top level applies polarity and produces the strobes.

Test Plan:
- Reset then run 2*1344*806 clocks with en=1 -> frame_start fires exactly twice, 1344*806 clocks apart; line_start fires 806 times per frame.
- Sample one full line -> hblnk rises at hcount=1024; hsync is active for exactly 136 clocks, starting at hcount=1048; hcount returns to 0 after 1343.
- Sample one full frame -> vblnk is 1 for vcount 768..805; vsync is active for exactly 6 lines, vcount 771..776; rgb is 0 throughout.
- Hold en=0 for 50 clocks starting at (hcount,vcount)=(500,10) -> all outputs frozen, strobes 0; with en=1 the next cycle shows (501,10).
- Assert rst_n=0 asynchronously at (1200,775), between clock edges -> outputs clear immediately, with sync at the inactive level; on release, counting restarts from (0,0).
- Set SYNC_ACTIVE_HIGH=0 -> hsync/vsync idle at 1 and go low during the same windows as above; reset value is 1.
